// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               valid/ready requesters. One operation in flight:
//               IDLE -> EXEC -> RESP -> IDLE.
//               Optional macro ALU_REQ_ARBITER_OVF_STICKY_EN adds a sticky
//               overflow flag (ovf_sticky) with a clear input (ovf_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int W  = 2,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [CW-1:0] req0_op,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [CW-1:0] req1_op,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [W:0]    rsp_result,
    output logic          rsp_ovf,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [CW-1:0] alu_ctrl,
    input  logic [W:0]    alu_result,
    input  logic          alu_ovf,
`ifdef ALU_REQ_ARBITER_OVF_STICKY_EN
    input  logic          ovf_clr,
    output logic          ovf_sticky,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          owner_q;
    logic [W-1:0]  alu_a_q, alu_b_q;
    logic [CW-1:0] alu_ctrl_q;
    logic [W:0]    rsp_result_q;
    logic          rsp_ovf_q;
    logic [1:0]    grant;
    logic          accept;
    logic          accept_id;

    // Round-robin grant: a lone requester always wins; on contention the
    // requester that was not served last wins. Re-evaluated every cycle.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    assign req_ready = (state_q == S_IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign accept_id = req_ready[1];

    // Next-state logic for the single-operation pipeline.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready[owner_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on request handshake; ALU outputs held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            alu_a_q      <= accept_id ? req1_a  : req0_a;
            alu_b_q      <= accept_id ? req1_b  : req0_b;
            alu_ctrl_q   <= accept_id ? req1_op : req0_op;
            owner_q      <= accept_id;
            last_grant_q <= accept_id;
        end
    end

    // Capture the full-width ALU result at the end of the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_result_q <= alu_result;
            rsp_ovf_q    <= alu_ovf;
        end
    end

`ifdef ALU_REQ_ARBITER_OVF_STICKY_EN
    logic ovf_sticky_q;

    // Sticky overflow: an overflow capture takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else if ((state_q == S_EXEC) && alu_ovf) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

    assign rsp_valid  = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = rsp_result_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Self-checking bench for alu_req_arbiter with a reference ALU
//               and a transaction-level model of the arbiter.
//               Honours ALU_REQ_ARBITER_OVF_STICKY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [2:0] req0_op, req1_op, alu_ctrl, rsp_result, alu_result;
    logic       rsp_ovf, alu_ovf, busy;
    logic       ovf_clr;
    logic       ovf_sticky_obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference ALU: add (overflow = sum bit 2), subtract (3-bit wrap),
    // and, xor, or, shift-left, invert-a, pass-b.
    function automatic logic [3:0] ref_alu(input logic [1:0] a, input logic [1:0] b,
                                           input logic [2:0] op);
        int ia, ib, r;
        logic ov;
        ia = int'(a);
        ib = int'(b);
        ov = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; ov = (r >= 4); end
            3'd1: r = (ia - ib + 8) % 8;
            3'd2: r = ia & ib;
            3'd3: r = ia ^ ib;
            3'd4: r = ia | ib;
            3'd5: r = ia * 2;
            3'd6: r = 3 - ia;
            default: r = ib;
        endcase
        ref_alu = {ov, 3'(r)};
    endfunction

    assign {alu_ovf, alu_result} = ref_alu(alu_a, alu_b, alu_ctrl);

    alu_req_arbiter #(.W(2), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
`ifdef ALU_REQ_ARBITER_OVF_STICKY_EN
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky_obs),
`endif
        .busy       (busy)
    );

`ifndef ALU_REQ_ARBITER_OVF_STICKY_EN
    assign ovf_sticky_obs = 1'b0;
`endif

    // Transaction-level model: phase 0 = waiting for a request,
    // 1 = operation computing, 2 = response offered to the owner.
    int         m_phase;
    logic       m_owner, m_last, m_ovf, m_sticky;
    logic [1:0] m_a, m_b;
    logic [2:0] m_op, m_res;
    logic       grants_q[$];

    task automatic model_reset();
        m_phase  = 0;
        m_owner  = 1'b0;
        m_last   = 1'b1;
        m_a      = 2'd0;
        m_b      = 2'd0;
        m_op     = 3'd0;
        m_res    = 3'd0;
        m_ovf    = 1'b0;
        m_sticky = 1'b0;
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v);
        if (v == 2'b11) return 2'b01 << int'(!m_last);
        return v;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("req_ready", 8'(req_ready), 8'((m_phase == 0) ? exp_grant(req_valid) : 2'b00));
        check("rsp_valid", 8'(rsp_valid),
              8'((m_phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00));
        check("busy", 8'(busy), 8'(m_phase != 0));
        check("rsp_result", 8'(rsp_result), 8'(m_res));
        check("rsp_ovf", 8'(rsp_ovf), 8'(m_ovf));
        check("alu_a", 8'(alu_a), 8'(m_a));
        check("alu_b", 8'(alu_b), 8'(m_b));
        check("alu_ctrl", 8'(alu_ctrl), 8'(m_op));
`ifdef ALU_REQ_ARBITER_OVF_STICKY_EN
        check("ovf_sticky", 8'(ovf_sticky_obs), 8'(m_sticky));
`endif
    endtask

    task automatic model_step();
        logic [1:0] g;
        logic [3:0] r;
        if (rst) begin
            model_reset();
            return;
        end
        r = ref_alu(m_a, m_b, m_op);
        if (m_phase == 1 && r[3]) m_sticky = 1'b1;
        else if (ovf_clr)         m_sticky = 1'b0;
        case (m_phase)
            0: begin
                g = exp_grant(req_valid);
                if (g != 2'b00) begin
                    m_owner = g[1];
                    m_last  = g[1];
                    m_a     = g[1] ? req1_a  : req0_a;
                    m_b     = g[1] ? req1_b  : req0_b;
                    m_op    = g[1] ? req1_op : req0_op;
                    grants_q.push_back(g[1]);
                    m_phase = 1;
                end
            end
            1: begin
                m_res   = r[2:0];
                m_ovf   = r[3];
                m_phase = 2;
            end
            default: if (rsp_ready[m_owner]) m_phase = 0;
        endcase
    endtask

    // One cycle: check outputs mid-cycle, then advance model at the edge.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input logic [1:0] v,
                           input logic [1:0] a0, input logic [1:0] b0, input logic [2:0] o0,
                           input logic [1:0] a1, input logic [1:0] b1, input logic [2:0] o1);
        req_valid = v;
        req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 2'b11;
        ovf_clr = 1'b0;
        set_req(2'b00, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single op: 3 + 2 on requester 0.
        set_req(2'b01, 2'd3, 2'd2, 3'd0, 2'd0, 2'd0, 3'd0);
        tick();
        req_valid = 2'b00;
        check("single_busy_exec", 8'(busy), 8'd1);
        tick();
        check("single_rsp_valid", 8'(rsp_valid), 8'h01);
        check("single_result", 8'(rsp_result), 8'h05);
        check("single_ovf", 8'(rsp_ovf), 8'h01);
        check("single_busy_resp", 8'(busy), 8'd1);
        tick();
        check("single_busy_done", 8'(busy), 8'd0);

        // Subtract wrap: 0 - 1.
        set_req(2'b01, 2'd0, 2'd1, 3'd1, 2'd0, 2'd0, 3'd0);
        tick();
        req_valid = 2'b00;
        tick();
        check("sub_result", 8'(rsp_result), 8'h07);
        check("sub_ovf", 8'(rsp_ovf), 8'h00);
        tick();

        // Contention: both held valid, grants must alternate 0,1,0.
        // Requester 1 was served last? No: requester 0 was, so start from a
        // reset to give requester 0 priority as required.
        rst = 1'b1;
        #1;
        model_reset();
        tick();
        rst = 1'b0;
        grants_q.delete();
        set_req(2'b11, 2'd1, 2'd1, 3'd0, 2'd2, 2'd1, 3'd4);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (rsp_valid == 2'b01) check("cont_res0", 8'(rsp_result), 8'h02);
            if (rsp_valid == 2'b10) check("cont_res1", 8'(rsp_result), 8'h03);
        end
        req_valid = 2'b00;
        check("cont_ngrants", 8'(grants_q.size()), 8'd3);
        if (grants_q.size() >= 3) begin
            check("cont_g0", 8'(grants_q[0]), 8'd0);
            check("cont_g1", 8'(grants_q[1]), 8'd1);
            check("cont_g2", 8'(grants_q[2]), 8'd0);
        end
        tick();

        // Back-pressure on requester 1 (non-owner ready is ignored).
        rsp_ready = 2'b00;
        set_req(2'b10, 2'd0, 2'd0, 3'd0, 2'd1, 2'd0, 3'd5);
        tick();
        req_valid = 2'b11;
        tick();
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", 8'(rsp_valid), 8'h02);
            check("bp_result", 8'(rsp_result), 8'h02);
            check("bp_req_ready", 8'(req_ready), 8'h00);
        end
        rsp_ready = 2'b10;
        req_valid = 2'b00;
        tick();
        check("bp_done", 8'(busy), 8'd0);
        rsp_ready = 2'b11;

        // Reset mid-operation (during EXEC).
        set_req(2'b10, 2'd0, 2'd0, 3'd0, 2'd3, 2'd3, 3'd0);
        tick();
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_alu_a", 8'(alu_a), 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("rst_no_rsp", 8'(rsp_valid), 8'h00);
        set_req(2'b11, 2'd2, 2'd2, 3'd2, 2'd1, 2'd1, 3'd3);
        #1;
        check("rst_first_grant", 8'(req_ready), 8'h01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();

`ifdef ALU_REQ_ARBITER_OVF_STICKY_EN
        // Sticky overflow set, held across a clean op, cleared, set-wins.
        set_req(2'b01, 2'd3, 2'd3, 3'd0, 2'd0, 2'd0, 3'd0);
        tick(); req_valid = 2'b00; tick(); tick();
        check("sticky_set", 8'(ovf_sticky_obs), 8'd1);
        set_req(2'b01, 2'd1, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0);
        tick(); req_valid = 2'b00; tick(); tick();
        check("sticky_hold", 8'(ovf_sticky_obs), 8'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("sticky_clear", 8'(ovf_sticky_obs), 8'd0);
        set_req(2'b01, 2'd3, 2'd1, 3'd0, 2'd0, 2'd0, 3'd0);
        tick(); req_valid = 2'b00;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("sticky_set_wins", 8'(ovf_sticky_obs), 8'd1);
        tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_req(2'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
                    2'($urandom), 2'($urandom), 3'($urandom));
            rsp_ready = 2'($urandom);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
